// File: rtl/dmem_arbiter.sv
// rtl/dmem_arbiter.sv - load/store arbiter for a single-ported data memory
// Loads take two cycles (issue + data return); stores complete in the issue cycle.
module dmem_arbiter #(
    parameter int unsigned FIXED_PRIO = 0
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        ld_req,
    input  logic [31:0] ld_addr,
    output logic        ld_gnt,
    output logic        ld_rvalid,
    output logic [31:0] ld_rdata,
    input  logic        st_req,
    input  logic [31:0] st_addr,
    input  logic [31:0] st_wdata,
    input  logic [3:0]  st_wstrb,
    output logic        st_gnt,
    output logic        mem_en,
    output logic        mem_rw_mode,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_wstrb,
    input  logic [31:0] mem_data,
    output logic        stall_pc,
    output logic [15:0] conflict_cnt
);

    typedef enum logic {
        IDLE    = 1'b0,
        RD_DATA = 1'b1
    } state_t;

    state_t      state_q, state_d;
    logic        last_grant_q, last_grant_d;
    logic [15:0] conflict_cnt_q, conflict_cnt_d;
    logic        grant_ld, grant_st;
    logic        both_req;

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            state_q        <= IDLE;
            last_grant_q   <= 1'b1;
            conflict_cnt_q <= 16'h0000;
        end else begin
            state_q        <= state_d;
            last_grant_q   <= last_grant_d;
            conflict_cnt_q <= conflict_cnt_d;
        end
    end

    // Everything is gated by i_rst so outputs go inactive the moment reset asserts.
    always_comb begin
        state_d        = state_q;
        last_grant_d   = last_grant_q;
        conflict_cnt_d = conflict_cnt_q;
        both_req       = ld_req & st_req;
        grant_ld       = 1'b0;
        grant_st       = 1'b0;
        ld_gnt         = 1'b0;
        st_gnt         = 1'b0;
        ld_rvalid      = 1'b0;
        ld_rdata       = 32'h0;
        mem_en         = 1'b0;
        mem_rw_mode    = 1'b1;
        mem_addr       = 32'h0;
        mem_wdata      = 32'h0;
        mem_wstrb      = 4'h0;
        stall_pc       = 1'b0;

        if (i_rst) begin
            case (state_q)
                IDLE: begin
                    if (both_req) begin
                        // last_grant_q=1 means the store won last time, so the load goes now
                        if ((FIXED_PRIO != 0) || last_grant_q) begin
                            grant_ld = 1'b1;
                        end else begin
                            grant_st = 1'b1;
                        end
                        if (conflict_cnt_q != 16'hFFFF) begin
                            conflict_cnt_d = conflict_cnt_q + 16'd1;
                        end
                    end else begin
                        grant_ld = ld_req;
                        grant_st = st_req;
                    end

                    if (grant_ld) begin
                        state_d      = RD_DATA;
                        last_grant_d = 1'b0;
                    end
                    if (grant_st) begin
                        last_grant_d = 1'b1;
                    end
                end
                RD_DATA: begin
                    state_d   = IDLE;
                    ld_rvalid = 1'b1;
                    ld_rdata  = mem_data;
                end
            endcase

            ld_gnt = grant_ld;
            st_gnt = grant_st;
            if (grant_ld) begin
                mem_en      = 1'b1;
                mem_rw_mode = 1'b1;
                mem_addr    = ld_addr;
            end else if (grant_st) begin
                mem_en      = 1'b1;
                mem_rw_mode = 1'b0;
                mem_addr    = st_addr;
                mem_wdata   = st_wdata;
                mem_wstrb   = st_wstrb;
            end

            stall_pc = (ld_req & ~grant_ld) | (st_req & ~grant_st) | (state_q == RD_DATA);
        end
    end

    assign conflict_cnt = conflict_cnt_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb/tb_dmem_arbiter.sv - self-checking bench for dmem_arbiter (round-robin and fixed-priority)
module tb_dmem_arbiter;

    typedef struct packed {
        logic        ld_gnt;
        logic        st_gnt;
        logic        rvalid;
        logic [31:0] rdata;
        logic        mem_en;
        logic        rw;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
        logic        stall;
        logic [15:0] cnt;
    } exp_t;

    logic        i_clk = 1'b0;
    logic        i_rst;
    logic        ld_req, st_req;
    logic [31:0] ld_addr, st_addr, st_wdata;
    logic [3:0]  st_wstrb;

    logic [1:0]        ld_gnt_a, ld_rvalid_a, st_gnt_a, mem_en_a, mem_rw_a, stall_a;
    logic [1:0][31:0]  ld_rdata_a, mem_addr_a, mem_wdata_a, mem_data_a;
    logic [1:0][3:0]   mem_wstrb_a;
    logic [1:0][15:0]  cnt_a;

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model: per instance, whether a read is outstanding, who won last, the
    // contention count as a plain integer, and a small word memory behind the arbiter.
    bit          m_busy    [2];
    bit          m_last_st [2];
    int          m_cnt     [2];
    logic [31:0] m_rword   [2];
    logic [31:0] m_mem     [2][16];

    always #5 i_clk = ~i_clk;

    dmem_arbiter #(.FIXED_PRIO(0)) dut0 (
        .i_clk(i_clk), .i_rst(i_rst),
        .ld_req(ld_req), .ld_addr(ld_addr), .ld_gnt(ld_gnt_a[0]),
        .ld_rvalid(ld_rvalid_a[0]), .ld_rdata(ld_rdata_a[0]),
        .st_req(st_req), .st_addr(st_addr), .st_wdata(st_wdata), .st_wstrb(st_wstrb),
        .st_gnt(st_gnt_a[0]), .mem_en(mem_en_a[0]), .mem_rw_mode(mem_rw_a[0]),
        .mem_addr(mem_addr_a[0]), .mem_wdata(mem_wdata_a[0]), .mem_wstrb(mem_wstrb_a[0]),
        .mem_data(mem_data_a[0]), .stall_pc(stall_a[0]), .conflict_cnt(cnt_a[0])
    );

    dmem_arbiter #(.FIXED_PRIO(1)) dut1 (
        .i_clk(i_clk), .i_rst(i_rst),
        .ld_req(ld_req), .ld_addr(ld_addr), .ld_gnt(ld_gnt_a[1]),
        .ld_rvalid(ld_rvalid_a[1]), .ld_rdata(ld_rdata_a[1]),
        .st_req(st_req), .st_addr(st_addr), .st_wdata(st_wdata), .st_wstrb(st_wstrb),
        .st_gnt(st_gnt_a[1]), .mem_en(mem_en_a[1]), .mem_rw_mode(mem_rw_a[1]),
        .mem_addr(mem_addr_a[1]), .mem_wdata(mem_wdata_a[1]), .mem_wstrb(mem_wstrb_a[1]),
        .mem_data(mem_data_a[1]), .stall_pc(stall_a[1]), .conflict_cnt(cnt_a[1])
    );

    function automatic exp_t actual(int p);
        exp_t a;
        a.ld_gnt = ld_gnt_a[p];
        a.st_gnt = st_gnt_a[p];
        a.rvalid = ld_rvalid_a[p];
        a.rdata  = ld_rdata_a[p];
        a.mem_en = mem_en_a[p];
        a.rw     = mem_rw_a[p];
        a.addr   = mem_addr_a[p];
        a.wdata  = mem_wdata_a[p];
        a.wstrb  = mem_wstrb_a[p];
        a.stall  = stall_a[p];
        a.cnt    = cnt_a[p];
        return a;
    endfunction

    function automatic exp_t predict(int p);
        exp_t e;
        int   win;
        e    = '0;
        e.rw = 1'b1;
        if (!i_rst) return e;
        e.cnt = 16'(m_cnt[p]);
        win   = 0;
        if (m_busy[p]) begin
            e.rvalid = 1'b1;
            e.rdata  = m_rword[p];
        end else if (ld_req && st_req) begin
            win = ((p == 1) || m_last_st[p]) ? 1 : 2;
        end else if (ld_req) begin
            win = 1;
        end else if (st_req) begin
            win = 2;
        end
        if (win == 1) begin
            e.ld_gnt = 1'b1; e.mem_en = 1'b1; e.addr = ld_addr;
        end else if (win == 2) begin
            e.st_gnt = 1'b1; e.mem_en = 1'b1; e.rw = 1'b0;
            e.addr = st_addr; e.wdata = st_wdata; e.wstrb = st_wstrb;
        end
        e.stall = (ld_req && win != 1) || (st_req && win != 2) || m_busy[p];
        return e;
    endfunction

    task automatic advance();
        for (int p = 0; p < 2; p++) begin
            exp_t e;
            e = predict(p);
            if (!i_rst) begin
                m_busy[p] = 0; m_last_st[p] = 1; m_cnt[p] = 0;
            end else begin
                if (!m_busy[p] && ld_req && st_req && m_cnt[p] < 65535) m_cnt[p]++;
                if (e.ld_gnt) begin
                    m_busy[p]    = 1;
                    m_last_st[p] = 0;
                    m_rword[p]   = m_mem[p][ld_addr[5:2]];
                end else begin
                    m_busy[p] = 0;
                    if (e.st_gnt) begin
                        m_last_st[p] = 1;
                        for (int b = 0; b < 4; b++)
                            if (st_wstrb[b]) m_mem[p][st_addr[5:2]][8*b +: 8] = st_wdata[8*b +: 8];
                    end
                end
            end
        end
        @(posedge i_clk);
        #1;
        for (int p = 0; p < 2; p++) mem_data_a[p] = m_busy[p] ? m_rword[p] : $urandom();
    endtask

    task automatic do_reset();
        i_rst = 1'b0; ld_req = 1'b0; st_req = 1'b0;
        advance();
        i_rst = 1'b1;
    endtask

    task automatic test_reset();
        i_rst = 1'b0; ld_req = 1'b1; st_req = 1'b1;
        ld_addr = 32'h0000_0200; st_addr = 32'h0000_0204; st_wdata = 32'h1234_5678; st_wstrb = 4'hF;
        for (int p = 0; p < 2; p++) begin
            m_busy[p] = 0; m_last_st[p] = 1; m_cnt[p] = 0; m_rword[p] = 32'h0;
            for (int i = 0; i < 16; i++) m_mem[p][i] = $urandom();
            mem_data_a[p] = 32'hCAFE_F00D;
        end
        #2;
        for (int p = 0; p < 2; p++) begin
            n_checks++;
            if (actual(p) !== 122'({1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 32'h0, 32'h0, 4'h0, 1'b0, 16'h0}))
                $display("FAIL reset_outputs p%0d got %h want rw=1 others 0", p, actual(p));
            else n_pass++;
        end
        ld_req = 1'b0; st_req = 1'b0;
        advance();
        i_rst = 1'b1;
    endtask

    task automatic test_single_load();
        do_reset();
        ld_req = 1'b1; ld_addr = 32'h0000_0100;
        @(negedge i_clk);
        n_checks++;
        if ({ld_gnt_a[0], mem_en_a[0], mem_rw_a[0], mem_addr_a[0], stall_a[0]} !== {1'b1, 1'b1, 1'b1, 32'h100, 1'b0})
            $display("FAIL load_issue got %h want %h",
                     {ld_gnt_a[0], mem_en_a[0], mem_rw_a[0], mem_addr_a[0], stall_a[0]}, {1'b1, 1'b1, 1'b1, 32'h100, 1'b0});
        else n_pass++;
        advance();
        ld_req = 1'b0; mem_data_a[0] = 32'hDEAD_BEEF;
        @(negedge i_clk);
        n_checks++;
        if ({ld_rvalid_a[0], ld_rdata_a[0], stall_a[0], mem_en_a[0], ld_gnt_a[0]} !== {1'b1, 32'hDEADBEEF, 1'b1, 1'b0, 1'b0})
            $display("FAIL load_data got %h want %h",
                     {ld_rvalid_a[0], ld_rdata_a[0], stall_a[0], mem_en_a[0], ld_gnt_a[0]}, {1'b1, 32'hDEADBEEF, 1'b1, 1'b0, 1'b0});
        else n_pass++;
        advance();
        @(negedge i_clk);
        n_checks++;
        if ({ld_rvalid_a[0], ld_rdata_a[0]} !== {1'b0, 32'h0})
            $display("FAIL load_after got %h want 0", {ld_rvalid_a[0], ld_rdata_a[0]});
        else n_pass++;
    endtask

    task automatic test_single_store();
        st_req = 1'b1; st_addr = 32'h24; st_wdata = 32'h55; st_wstrb = 4'b0001;
        @(negedge i_clk);
        n_checks++;
        if ({st_gnt_a[0], mem_en_a[0], mem_rw_a[0], mem_addr_a[0], mem_wdata_a[0], mem_wstrb_a[0], stall_a[0]}
            !== {1'b1, 1'b1, 1'b0, 32'h24, 32'h55, 4'b0001, 1'b0})
            $display("FAIL store_issue got %h want %h",
                     {st_gnt_a[0], mem_en_a[0], mem_rw_a[0], mem_addr_a[0], mem_wdata_a[0], mem_wstrb_a[0], stall_a[0]},
                     {1'b1, 1'b1, 1'b0, 32'h24, 32'h55, 4'b0001, 1'b0});
        else n_pass++;
        advance();
        st_req = 1'b0; ld_req = 1'b1; ld_addr = 32'h40;
        @(negedge i_clk);
        n_checks++;
        if ({ld_gnt_a[0], ld_rvalid_a[0], stall_a[0]} !== 3'b100)
            $display("FAIL store_stays_idle got %b want 100", {ld_gnt_a[0], ld_rvalid_a[0], stall_a[0]});
        else n_pass++;
        advance();
        ld_req = 1'b0;
        advance();
        st_req = 1'b1; st_addr = 32'h28; st_wdata = 32'hFFFF_FFFF; st_wstrb = 4'b0000;
        @(negedge i_clk);
        n_checks++;
        if ({st_gnt_a[0], mem_en_a[0], mem_rw_a[0], mem_wstrb_a[0]} !== {1'b1, 1'b1, 1'b0, 4'b0000})
            $display("FAIL store_zero_strobe got %h want %h",
                     {st_gnt_a[0], mem_en_a[0], mem_rw_a[0], mem_wstrb_a[0]}, {1'b1, 1'b1, 1'b0, 4'b0000});
        else n_pass++;
        advance();
        st_req = 1'b0;
    endtask

    task automatic test_contention();
        bit ld_exp [4] = '{1'b1, 1'b0, 1'b0, 1'b1};
        bit st_exp [4] = '{1'b0, 1'b0, 1'b1, 1'b0};
        bit rv_exp [4] = '{1'b0, 1'b1, 1'b0, 1'b0};
        do_reset();
        ld_req = 1'b1; st_req = 1'b1; ld_addr = 32'h80; st_addr = 32'h84; st_wdata = 32'hA5A5; st_wstrb = 4'hF;
        for (int c = 0; c < 4; c++) begin
            @(negedge i_clk);
            n_checks++;
            if ({ld_gnt_a[0], st_gnt_a[0], ld_rvalid_a[0], stall_a[0]} !== {ld_exp[c], st_exp[c], rv_exp[c], 1'b1})
                $display("FAIL contention_c%0d got %b want %b", c,
                         {ld_gnt_a[0], st_gnt_a[0], ld_rvalid_a[0], stall_a[0]}, {ld_exp[c], st_exp[c], rv_exp[c], 1'b1});
            else n_pass++;
            if (c == 3) begin
                n_checks++;
                if (cnt_a[0] !== 16'd2) $display("FAIL contention_cnt got %0d want 2", cnt_a[0]);
                else n_pass++;
            end
            advance();
        end
        ld_req = 1'b0; st_req = 1'b0;
        advance();
    endtask

    task automatic test_fixed_prio();
        do_reset();
        ld_req = 1'b1; st_req = 1'b1; ld_addr = 32'h10; st_addr = 32'h14; st_wdata = 32'h1; st_wstrb = 4'h1;
        for (int c = 0; c < 6; c++) begin
            @(negedge i_clk);
            n_checks++;
            if ({st_gnt_a[1], stall_a[1], ld_gnt_a[1]} !== {1'b0, 1'b1, ((c % 2) == 0)})
                $display("FAIL fixed_prio_c%0d got %b want %b", c,
                         {st_gnt_a[1], stall_a[1], ld_gnt_a[1]}, {1'b0, 1'b1, ((c % 2) == 0)});
            else n_pass++;
            advance();
        end
        ld_req = 1'b0; st_req = 1'b0;
        advance();
    endtask

    task automatic test_reset_mid_read();
        do_reset();
        ld_req = 1'b1; ld_addr = 32'h300;
        advance();
        ld_req = 1'b0; st_req = 1'b1; st_addr = 32'h304; st_wdata = 32'h77; st_wstrb = 4'hF;
        #2;
        i_rst = 1'b0;
        #1;
        n_checks++;
        if (actual(0) !== 122'({1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 32'h0, 32'h0, 4'h0, 1'b0, 16'h0}))
            $display("FAIL reset_mid_read got %h want rw=1 others 0", actual(0));
        else n_pass++;
        advance();
        i_rst = 1'b1; st_req = 1'b0;
        for (int c = 0; c < 2; c++) begin
            @(negedge i_clk);
            n_checks++;
            if ({ld_rvalid_a[0], stall_a[0], mem_en_a[0]} !== 3'b000)
                $display("FAIL after_abort_c%0d got %b want 000", c, {ld_rvalid_a[0], stall_a[0], mem_en_a[0]});
            else n_pass++;
            advance();
        end
    endtask

    task automatic test_saturation();
        do_reset();
        force dut0.conflict_cnt_q = 16'hFFFD;
        #1;
        release dut0.conflict_cnt_q;
        m_cnt[0] = 65533;
        ld_req = 1'b1; st_req = 1'b1; ld_addr = 32'h8; st_addr = 32'hC; st_wdata = 32'h3; st_wstrb = 4'h3;
        for (int c = 0; c < 7; c++) begin
            @(negedge i_clk);
            n_checks++;
            if (cnt_a[0] !== 16'(m_cnt[0])) $display("FAIL sat_c%0d got %h want %h", c, cnt_a[0], 16'(m_cnt[0]));
            else n_pass++;
            advance();
        end
        @(negedge i_clk);
        n_checks++;
        if (cnt_a[0] !== 16'hFFFF) $display("FAIL sat_final got %h want ffff", cnt_a[0]);
        else n_pass++;
        ld_req = 1'b0; st_req = 1'b0;
        advance();
        advance();
    endtask

    task automatic test_random();
        exp_t a, e;
        do_reset();
        for (int c = 0; c < 400; c++) begin
            i_rst    = ($urandom_range(0, 49) != 0);
            ld_req   = ($urandom_range(0, 9) < 6);
            st_req   = ($urandom_range(0, 9) < 5);
            ld_addr  = $urandom();
            st_addr  = $urandom();
            st_wdata = $urandom();
            st_wstrb = 4'($urandom());
            @(negedge i_clk);
            for (int p = 0; p < 2; p++) begin
                a = actual(p);
                e = predict(p);
                n_checks++;
                if (a !== e) $display("FAIL random p%0d cyc%0d got %h want %h", p, c, a, e);
                else n_pass++;
            end
            advance();
        end
        i_rst = 1'b1; ld_req = 1'b0; st_req = 1'b0;
        advance();
    endtask

    initial begin
        test_reset();
        test_single_load();
        test_single_store();
        test_contention();
        test_fixed_prio();
        test_reset_mid_read();
        test_saturation();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
